// File: rtl/ex_stage_if.sv
// Decoded-op encodings shared by ID and EX, and the ID/EX + EX/MEM bundle seen by the execute stage.
package ex_mnemonic_pkg;
  localparam logic [5:0] MN_BUBBLE = 6'd0;
  localparam logic [5:0] MN_ADD    = 6'd1;
  localparam logic [5:0] MN_SUB    = 6'd2;
  localparam logic [5:0] MN_SLL    = 6'd3;
  localparam logic [5:0] MN_SLT    = 6'd4;
  localparam logic [5:0] MN_SLTU   = 6'd5;
  localparam logic [5:0] MN_XOR    = 6'd6;
  localparam logic [5:0] MN_SRL    = 6'd7;
  localparam logic [5:0] MN_SRA    = 6'd8;
  localparam logic [5:0] MN_OR     = 6'd9;
  localparam logic [5:0] MN_AND    = 6'd10;
  localparam logic [5:0] MN_LUI    = 6'd11;
  localparam logic [5:0] MN_AUIPC  = 6'd12;
  localparam logic [5:0] MN_LOAD   = 6'd13;
  localparam logic [5:0] MN_STORE  = 6'd14;
  localparam logic [5:0] MN_JAL    = 6'd15;
  localparam logic [5:0] MN_JALR   = 6'd16;
  localparam logic [5:0] MN_BRANCH = 6'd17;
endpackage

interface ex_stage_if #(
  parameter int XLEN = 32
);
  logic [5:0]      i_mnemonic;
  logic [XLEN-1:0] i_rs1_data;
  logic [XLEN-1:0] i_rs2_data;
  logic [4:0]      i_rs1_addr;
  logic [4:0]      i_rs2_addr;
  logic [4:0]      i_rd_addr;
  logic            i_rd_wr;
  logic [XLEN-1:0] i_imm;
  logic            i_ALUsrc1;
  logic            i_ALUsrc2;
  logic [XLEN-1:0] i_pc;
  logic            i_DM_OE;
  logic            i_store;
  logic [2:0]      i_funct3;
  logic            i_b_inst;
  logic            i_jal;
  logic            i_jalr;
  logic            i_mem_rd_wr;
  logic [4:0]      i_mem_rd_addr;
  logic [XLEN-1:0] i_mem_result;
  logic            i_wb_rd_wr;
  logic [4:0]      i_wb_rd_addr;
  logic [XLEN-1:0] i_wb_data;
  logic            i_mem_stall;
  logic            o_flush;
  logic [XLEN-1:0] o_redirect_pc;
  logic [XLEN-1:0] o_alu_result;
  logic [XLEN-1:0] o_store_data;
  logic [4:0]      o_rd_addr;
  logic            o_rd_wr;
  logic            o_DM_OE;
  logic            o_store;
  logic [2:0]      o_funct3;

  modport slave (
    input  i_mnemonic, i_rs1_data, i_rs2_data, i_rs1_addr, i_rs2_addr, i_rd_addr, i_rd_wr,
           i_imm, i_ALUsrc1, i_ALUsrc2, i_pc, i_DM_OE, i_store, i_funct3, i_b_inst, i_jal,
           i_jalr, i_mem_rd_wr, i_mem_rd_addr, i_mem_result, i_wb_rd_wr, i_wb_rd_addr,
           i_wb_data, i_mem_stall,
    output o_flush, o_redirect_pc, o_alu_result, o_store_data, o_rd_addr, o_rd_wr, o_DM_OE,
           o_store, o_funct3
  );

  modport master (
    output i_mnemonic, i_rs1_data, i_rs2_data, i_rs1_addr, i_rs2_addr, i_rd_addr, i_rd_wr,
           i_imm, i_ALUsrc1, i_ALUsrc2, i_pc, i_DM_OE, i_store, i_funct3, i_b_inst, i_jal,
           i_jalr, i_mem_rd_wr, i_mem_rd_addr, i_mem_result, i_wb_rd_wr, i_wb_rd_addr,
           i_wb_data, i_mem_stall,
    input  o_flush, o_redirect_pc, o_alu_result, o_store_data, o_rd_addr, o_rd_wr, o_DM_OE,
           o_store, o_funct3
  );
endinterface

// File: rtl/ex_stage.sv
// RV32I execute stage: operand forwarding, ALU, branch/jump resolution with one-shot
// redirect, and the stall-aware EX/MEM pipeline register.
module ex_stage
  import ex_mnemonic_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic       clk,
  input logic       rst,
  ex_stage_if.slave ex
);

  logic [4:0]      src_addr [2];
  logic [XLEN-1:0] src_data [2];
  logic [XLEN-1:0] fwd      [2];

  logic [XLEN-1:0] op_a, op_b, alu_out, ex_result, target;
  logic [4:0]      shamt;
  logic            cond, taken, flush;

  logic [XLEN-1:0] redirect_pc_reg;
  logic            redirect_done_reg;
  logic [XLEN-1:0] alu_result_reg, store_data_reg;
  logic [4:0]      rd_addr_reg;
  logic            rd_wr_reg, dm_oe_reg, store_reg;
  logic [2:0]      funct3_reg;

  assign src_addr[0] = ex.i_rs1_addr;
  assign src_addr[1] = ex.i_rs2_addr;
  assign src_data[0] = ex.i_rs1_data;
  assign src_data[1] = ex.i_rs2_data;

  // EX/MEM beats MEM/WB because it holds the younger write to the same register.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      assign fwd[gi] =
        (ex.i_mem_rd_wr && (ex.i_mem_rd_addr != 5'd0) && (ex.i_mem_rd_addr == src_addr[gi])) ? ex.i_mem_result :
        (ex.i_wb_rd_wr  && (ex.i_wb_rd_addr  != 5'd0) && (ex.i_wb_rd_addr  == src_addr[gi])) ? ex.i_wb_data    :
        src_data[gi];
    end
  endgenerate

  assign op_a  = ex.i_ALUsrc1 ? ex.i_pc  : fwd[0];
  assign op_b  = ex.i_ALUsrc2 ? ex.i_imm : fwd[1];
  assign shamt = op_b[4:0];

  always_comb begin
    alu_out = '0;
    case (ex.i_mnemonic)
      MN_ADD, MN_LOAD, MN_STORE, MN_AUIPC: alu_out = op_a + op_b;
      MN_SUB:  alu_out = op_a - op_b;
      MN_SLL:  alu_out = op_a << shamt;
      MN_SRL:  alu_out = op_a >> shamt;
      MN_SRA:  alu_out = $signed(op_a) >>> shamt;
      MN_SLT:  alu_out = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      MN_SLTU: alu_out = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      MN_XOR:  alu_out = op_a ^ op_b;
      MN_OR:   alu_out = op_a | op_b;
      MN_AND:  alu_out = op_a & op_b;
      MN_LUI:  alu_out = op_b;
      default: alu_out = '0;
    endcase
  end

  assign ex_result = (ex.i_jal || ex.i_jalr) ? (ex.i_pc + XLEN'(4)) : alu_out;

  always_comb begin
    cond = 1'b0;
    case (ex.i_funct3)
      3'b000:  cond = (fwd[0] == fwd[1]);
      3'b001:  cond = (fwd[0] != fwd[1]);
      3'b100:  cond = ($signed(fwd[0]) <  $signed(fwd[1]));
      3'b101:  cond = ($signed(fwd[0]) >= $signed(fwd[1]));
      3'b110:  cond = (fwd[0] <  fwd[1]);
      3'b111:  cond = (fwd[0] >= fwd[1]);
      default: cond = 1'b0;
    endcase
  end

  assign target = ex.i_jalr ? ((fwd[0] + ex.i_imm) & {{(XLEN-1){1'b1}}, 1'b0})
                            : (ex.i_pc + ex.i_imm);
  assign taken  = (ex.i_b_inst & cond) | ex.i_jal | ex.i_jalr;
  // redirect_done suppresses a second flush while the same control op waits out a stall.
  assign flush  = taken & ~redirect_done_reg & ~rst;

  assign ex.o_flush       = flush;
  assign ex.o_redirect_pc = flush ? target : redirect_pc_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_pc_reg   <= RESET_PC;
      redirect_done_reg <= 1'b0;
      alu_result_reg    <= '0;
      store_data_reg    <= '0;
      rd_addr_reg       <= '0;
      rd_wr_reg         <= 1'b0;
      dm_oe_reg         <= 1'b0;
      store_reg         <= 1'b0;
      funct3_reg        <= '0;
    end else begin
      if (flush) begin
        redirect_pc_reg <= target;
      end
      if (!ex.i_mem_stall) begin
        redirect_done_reg <= 1'b0;
        alu_result_reg    <= ex_result;
        store_data_reg    <= fwd[1];
        rd_addr_reg       <= ex.i_rd_addr;
        rd_wr_reg         <= ex.i_rd_wr;
        dm_oe_reg         <= ex.i_DM_OE;
        store_reg         <= ex.i_store;
        funct3_reg        <= ex.i_funct3;
      end else if (flush) begin
        redirect_done_reg <= 1'b1;
      end
    end
  end

  assign ex.o_alu_result = alu_result_reg;
  assign ex.o_store_data = store_data_reg;
  assign ex.o_rd_addr    = rd_addr_reg;
  assign ex.o_rd_wr      = rd_wr_reg;
  assign ex.o_DM_OE      = dm_oe_reg;
  assign ex.o_store      = store_reg;
  assign ex.o_funct3     = funct3_reg;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed scenarios plus randomized cycles against a behavioural model.
module tb_ex_stage;
  import ex_mnemonic_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  ex_stage_if #(.XLEN(32)) bus();

  ex_stage #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk(clk),
    .rst(rst),
    .ex (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic idle();
    bus.i_mnemonic = MN_BUBBLE; bus.i_rs1_data = 0; bus.i_rs2_data = 0;
    bus.i_rs1_addr = 0; bus.i_rs2_addr = 0; bus.i_rd_addr = 0; bus.i_rd_wr = 0;
    bus.i_imm = 0; bus.i_ALUsrc1 = 0; bus.i_ALUsrc2 = 0; bus.i_pc = 0;
    bus.i_DM_OE = 0; bus.i_store = 0; bus.i_funct3 = 0; bus.i_b_inst = 0;
    bus.i_jal = 0; bus.i_jalr = 0; bus.i_mem_rd_wr = 0; bus.i_mem_rd_addr = 0;
    bus.i_mem_result = 0; bus.i_wb_rd_wr = 0; bus.i_wb_rd_addr = 0; bus.i_wb_data = 0;
    bus.i_mem_stall = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [5:0] mn, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
    idle();
    bus.i_mnemonic = mn; bus.i_rs1_addr = 5'd1; bus.i_rs2_addr = 5'd2;
    bus.i_rs1_data = a; bus.i_rs2_data = b; bus.i_rd_addr = rd; bus.i_rd_wr = 1'b1;
  endtask

  // ---------------- behavioural reference ----------------
  function automatic logic [31:0] m_fwd(input logic [4:0] a, input logic [31:0] rf);
    if (a == 5'd0) return rf;
    if (bus.i_mem_rd_wr && bus.i_mem_rd_addr == a) return bus.i_mem_result;
    if (bus.i_wb_rd_wr && bus.i_wb_rd_addr == a) return bus.i_wb_data;
    return rf;
  endfunction

  function automatic logic [31:0] m_result(input logic [31:0] f1, input logic [31:0] f2);
    logic [31:0] a, b;
    int sa;
    a = bus.i_ALUsrc1 ? bus.i_pc : f1;
    b = bus.i_ALUsrc2 ? bus.i_imm : f2;
    sa = int'(b % 32);
    if (bus.i_jal || bus.i_jalr) return bus.i_pc + 32'd4;
    case (bus.i_mnemonic)
      MN_ADD, MN_LOAD, MN_STORE, MN_AUIPC: return a + b;
      MN_SUB:  return a - b;
      MN_SLL:  return a << sa;
      MN_SRL:  return a >> sa;
      MN_SRA:  return 32'(int'(a) >>> sa);
      MN_SLT:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      MN_SLTU: return ({1'b0, a} < {1'b0, b}) ? 32'd1 : 32'd0;
      MN_XOR:  return a ^ b;
      MN_OR:   return a | b;
      MN_AND:  return a & b;
      MN_LUI:  return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic m_taken(input logic [31:0] f1, input logic [31:0] f2);
    if (bus.i_jal || bus.i_jalr) return 1'b1;
    if (!bus.i_b_inst) return 1'b0;
    case (bus.i_funct3)
      3'd0: return f1 == f2;
      3'd1: return f1 != f2;
      3'd4: return int'(f1) < int'(f2);
      3'd5: return int'(f1) >= int'(f2);
      3'd6: return {1'b0, f1} < {1'b0, f2};
      3'd7: return {1'b0, f1} >= {1'b0, f2};
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_target(input logic [31:0] f1);
    if (bus.i_jalr) return (f1 + bus.i_imm) & 32'hFFFF_FFFE;
    return bus.i_pc + bus.i_imm;
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [82:0] regs;
    idle();
    rst = 1'b1;
    #3;
    regs = {bus.o_alu_result, bus.o_store_data, bus.o_rd_addr, bus.o_rd_wr, bus.o_DM_OE,
            bus.o_store, bus.o_funct3, bus.o_flush};
    checks++;
    if (regs !== '0) begin
      $display("FAIL reset_outputs got=%h exp=0", regs); failures++;
    end
    checks++;
    if (bus.o_redirect_pc !== 32'h0) begin
      $display("FAIL reset_redirect_pc got=%h exp=00000000", bus.o_redirect_pc); failures++;
    end
    step();
    step();
    rst = 1'b0;
    #1;
    $display("reset: regs=%h redirect_pc=%h", regs, bus.o_redirect_pc);
  endtask

  task automatic test_add();
    set_op(MN_ADD, 32'd5, 32'd7, 5'd3);
    step();
    checks++;
    if (bus.o_alu_result !== 32'd12) begin
      $display("FAIL add_result got=%h exp=0000000c", bus.o_alu_result); failures++;
    end
    checks++;
    if ({bus.o_rd_addr, bus.o_rd_wr} !== {5'd3, 1'b1}) begin
      $display("FAIL add_rd got=%0d/%0b exp=3/1", bus.o_rd_addr, bus.o_rd_wr); failures++;
    end
    $display("add: x3 = 5+7 -> %0d", bus.o_alu_result);
  endtask

  task automatic test_forwarding();
    logic [31:0] exp_v [3] = '{32'h11, 32'h21, 32'h1};
    for (int k = 0; k < 3; k++) begin
      idle();
      bus.i_mnemonic = MN_ADD; bus.i_ALUsrc2 = 1'b1; bus.i_imm = 32'd1;
      bus.i_rs1_addr = (k == 2) ? 5'd0 : 5'd5; bus.i_rs1_data = 32'd0;
      bus.i_mem_rd_wr = (k != 1); bus.i_mem_rd_addr = (k == 2) ? 5'd0 : 5'd5;
      bus.i_mem_result = 32'h10;
      bus.i_wb_rd_wr = 1'b1; bus.i_wb_rd_addr = (k == 2) ? 5'd0 : 5'd5; bus.i_wb_data = 32'h20;
      bus.i_rd_addr = 5'd6; bus.i_rd_wr = 1'b1;
      step();
      checks++;
      if (bus.o_alu_result !== exp_v[k]) begin
        $display("FAIL fwd_case%0d got=%h exp=%h", k, bus.o_alu_result, exp_v[k]); failures++;
      end
      $display("forward case %0d: result=%h", k, bus.o_alu_result);
    end
  endtask

  task automatic test_branch();
    logic [2:0] f3   [5] = '{3'b100, 3'b110, 3'b101, 3'b001, 3'b010};
    logic       expf [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 5; k++) begin
      set_op(MN_BRANCH, 32'hFFFF_FFFF, 32'd1, 5'd0);
      bus.i_rd_wr = 1'b0; bus.i_b_inst = 1'b1; bus.i_funct3 = f3[k];
      bus.i_pc = 32'h100; bus.i_imm = 32'hFFFF_FFF8;
      #1;
      checks++;
      if (bus.o_flush !== expf[k]) begin
        $display("FAIL branch_flush_f3=%0d got=%0b exp=%0b", f3[k], bus.o_flush, expf[k]); failures++;
      end
      checks++;
      if (bus.o_redirect_pc !== 32'hF8) begin
        $display("FAIL branch_pc_f3=%0d got=%h exp=000000f8", f3[k], bus.o_redirect_pc); failures++;
      end
      $display("branch f3=%0d: flush=%0b redirect=%h", f3[k], bus.o_flush, bus.o_redirect_pc);
      step();
    end
  endtask

  task automatic test_jalr();
    set_op(MN_JALR, 32'h2003, 32'd0, 5'd1);
    bus.i_jalr = 1'b1; bus.i_ALUsrc2 = 1'b1; bus.i_imm = 32'd4; bus.i_pc = 32'h40;
    #1;
    checks++;
    if ({bus.o_flush, bus.o_redirect_pc} !== {1'b1, 32'h2006}) begin
      $display("FAIL jalr_redirect got=%0b/%h exp=1/00002006", bus.o_flush, bus.o_redirect_pc); failures++;
    end
    step();
    checks++;
    if ({bus.o_alu_result, bus.o_rd_addr, bus.o_rd_wr} !== {32'h44, 5'd1, 1'b1}) begin
      $display("FAIL jalr_link got=%h/%0d/%0b exp=00000044/1/1", bus.o_alu_result, bus.o_rd_addr, bus.o_rd_wr);
      failures++;
    end
    $display("jalr: redirect=00002006 link=%h", bus.o_alu_result);
  endtask

  task automatic test_jal_stall();
    set_op(MN_ADD, 32'd1, 32'd2, 5'd7);
    step();
    set_op(MN_JAL, 32'd0, 32'd0, 5'd1);
    bus.i_jal = 1'b1; bus.i_pc = 32'h80; bus.i_imm = 32'h20; bus.i_mem_stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if ({bus.o_flush, bus.o_redirect_pc} !== {(c == 0), 32'hA0}) begin
        $display("FAIL jal_stall_flush_c%0d got=%0b/%h exp=%0b/000000a0", c, bus.o_flush,
                 bus.o_redirect_pc, (c == 0)); failures++;
      end
      checks++;
      if ({bus.o_alu_result, bus.o_rd_addr} !== {32'd3, 5'd7}) begin
        $display("FAIL jal_stall_hold_c%0d got=%h/%0d exp=00000003/7", c, bus.o_alu_result, bus.o_rd_addr);
        failures++;
      end
      $display("jal stall cycle %0d: flush=%0b alu=%h", c, bus.o_flush, bus.o_alu_result);
      step();
    end
    bus.i_mem_stall = 1'b0;
    #1;
    checks++;
    if (bus.o_flush !== 1'b0) begin
      $display("FAIL jal_release_flush got=%0b exp=0", bus.o_flush); failures++;
    end
    step();
    checks++;
    if ({bus.o_alu_result, bus.o_rd_addr} !== {32'h84, 5'd1}) begin
      $display("FAIL jal_release_link got=%h/%0d exp=00000084/1", bus.o_alu_result, bus.o_rd_addr); failures++;
    end
    $display("jal release: link=%h", bus.o_alu_result);
    idle();
    step();
  endtask

  task automatic test_reset_mid_stall();
    logic [82:0] regs;
    set_op(MN_ADD, 32'd9, 32'd9, 5'd4);
    step();
    set_op(MN_JAL, 32'd0, 32'd0, 5'd1);
    bus.i_jal = 1'b1; bus.i_pc = 32'h200; bus.i_imm = 32'h10; bus.i_mem_stall = 1'b1;
    step();
    checks++;
    if (bus.o_flush !== 1'b0) begin
      $display("FAIL rst_stall_preflush got=%0b exp=0", bus.o_flush); failures++;
    end
    rst = 1'b1;
    #1;
    regs = {bus.o_alu_result, bus.o_store_data, bus.o_rd_addr, bus.o_rd_wr, bus.o_DM_OE,
            bus.o_store, bus.o_funct3, bus.o_flush};
    checks++;
    if ({regs, bus.o_redirect_pc} !== '0) begin
      $display("FAIL rst_stall_clear got=%h/%h exp=0/0", regs, bus.o_redirect_pc); failures++;
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.o_flush, bus.o_redirect_pc} !== {1'b1, 32'h210}) begin
      $display("FAIL rst_stall_reflush got=%0b/%h exp=1/00000210", bus.o_flush, bus.o_redirect_pc); failures++;
    end
    step();
    checks++;
    if (bus.o_flush !== 1'b0) begin
      $display("FAIL rst_stall_once got=%0b exp=0", bus.o_flush); failures++;
    end
    bus.i_mem_stall = 1'b0;
    step();
    checks++;
    if (bus.o_alu_result !== 32'h204) begin
      $display("FAIL rst_stall_link got=%h exp=00000204", bus.o_alu_result); failures++;
    end
    $display("reset mid-stall: cleared, reflush to 00000210, link=%h", bus.o_alu_result);
    idle();
    step();
  endtask

  task automatic test_back_to_back();
    logic [5:0]  mn  [12] = '{MN_SUB, MN_SLL, MN_SRL, MN_SRA, MN_SLT, MN_SLTU, MN_XOR,
                              MN_OR, MN_AND, MN_LUI, 6'd63, MN_ADD};
    logic [31:0] av  [12] = '{32'd10, 32'd1, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF,
                              32'hFFFF_FFFF, 32'hF0F0, 32'hF0F0, 32'hF0F0, 32'd0, 32'd5,
                              32'hFFFF_FFFF};
    logic [31:0] bv  [12] = '{32'd3, 32'd36, 32'd4, 32'd4, 32'd1, 32'd1, 32'hFF00, 32'h0F00,
                              32'hFF00, 32'h1234_5000, 32'd6, 32'd2};
    logic [31:0] ev  [12] = '{32'd7, 32'd16, 32'h0800_0000, 32'hF800_0000, 32'd1, 32'd0,
                              32'h0FF0, 32'hFFF0, 32'hF000, 32'h1234_5000, 32'd0, 32'd1};
    for (int k = 0; k < 12; k++) begin
      set_op(mn[k], av[k], bv[k], 5'(k + 1));
      step();
      checks++;
      if ({bus.o_alu_result, bus.o_store_data, bus.o_rd_addr} !== {ev[k], bv[k], 5'(k + 1)}) begin
        $display("FAIL b2b_op%0d got=%h/%h/%0d exp=%h/%h/%0d", mn[k], bus.o_alu_result,
                 bus.o_store_data, bus.o_rd_addr, ev[k], bv[k], k + 1); failures++;
      end
      $display("b2b op=%0d a=%h b=%h -> %h", mn[k], av[k], bv[k], bus.o_alu_result);
    end
  endtask

  task automatic test_random();
    logic [31:0] m_alu, m_sd, m_hold, f1, f2, tgt, exp_rpc;
    logic [4:0]  m_rd;
    logic [2:0]  m_f3;
    logic        m_rdwr, m_oe, m_st, m_done, exp_flush;
    int          cls, mnr;
    idle();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    {m_alu, m_sd, m_hold, m_rd, m_f3, m_rdwr, m_oe, m_st, m_done} = '0;
    for (int n = 0; n < 300; n++) begin
      if (n == 0 || $urandom_range(0, 2) != 0) begin
        mnr = $urandom_range(0, 18);
        bus.i_mnemonic = (mnr == 18) ? 6'd63 : 6'(mnr);
        bus.i_rs1_addr = 5'($urandom_range(0, 3)); bus.i_rs2_addr = 5'($urandom_range(0, 3));
        bus.i_rs1_data = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 8));
        bus.i_rs2_data = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 8));
        bus.i_rd_addr = 5'($urandom); bus.i_rd_wr = 1'($urandom);
        bus.i_imm = ($urandom_range(0, 1) != 0) ? $urandom : 32'($signed($urandom_range(0, 63)) - 32);
        bus.i_ALUsrc1 = 1'($urandom); bus.i_ALUsrc2 = 1'($urandom);
        bus.i_pc = $urandom & 32'hFFFF_FFFC;
        bus.i_DM_OE = 1'($urandom); bus.i_store = 1'($urandom); bus.i_funct3 = 3'($urandom);
        cls = $urandom_range(0, 9);
        bus.i_b_inst = (cls < 3); bus.i_jal = (cls == 3); bus.i_jalr = (cls == 4);
        bus.i_mem_rd_wr = 1'($urandom); bus.i_mem_rd_addr = 5'($urandom_range(0, 3));
        bus.i_mem_result = $urandom;
        bus.i_wb_rd_wr = 1'($urandom); bus.i_wb_rd_addr = 5'($urandom_range(0, 3));
        bus.i_wb_data = $urandom;
      end
      bus.i_mem_stall = ($urandom_range(0, 2) == 0);
      #1;
      f1 = m_fwd(bus.i_rs1_addr, bus.i_rs1_data);
      f2 = m_fwd(bus.i_rs2_addr, bus.i_rs2_data);
      tgt = m_target(f1);
      exp_flush = m_taken(f1, f2) && !m_done;
      exp_rpc = exp_flush ? tgt : m_hold;
      checks++;
      if ({bus.o_flush, bus.o_redirect_pc} !== {exp_flush, exp_rpc}) begin
        $display("FAIL rand%0d_redirect got=%0b/%h exp=%0b/%h", n, bus.o_flush, bus.o_redirect_pc,
                 exp_flush, exp_rpc); failures++;
      end
      if (exp_flush) m_hold = tgt;
      if (!bus.i_mem_stall) begin
        m_alu = m_result(f1, f2); m_sd = f2; m_rd = bus.i_rd_addr; m_rdwr = bus.i_rd_wr;
        m_oe = bus.i_DM_OE; m_st = bus.i_store; m_f3 = bus.i_funct3; m_done = 1'b0;
      end else if (exp_flush) begin
        m_done = 1'b1;
      end
      step();
      checks++;
      if ({bus.o_alu_result, bus.o_store_data, bus.o_rd_addr, bus.o_rd_wr, bus.o_DM_OE,
           bus.o_store, bus.o_funct3} !== {m_alu, m_sd, m_rd, m_rdwr, m_oe, m_st, m_f3}) begin
        $display("FAIL rand%0d_exmem got=%h/%h/%0d/%0b%0b%0b/%0d exp=%h/%h/%0d/%0b%0b%0b/%0d", n,
                 bus.o_alu_result, bus.o_store_data, bus.o_rd_addr, bus.o_rd_wr, bus.o_DM_OE,
                 bus.o_store, bus.o_funct3, m_alu, m_sd, m_rd, m_rdwr, m_oe, m_st, m_f3);
        failures++;
      end
      $display("rand %0d: op=%0d stall=%0b flush=%0b alu=%h", n, bus.i_mnemonic, bus.i_mem_stall,
               exp_flush, bus.o_alu_result);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_forwarding();
    test_branch();
    test_jalr();
    test_jal_stall();
    test_reset_mid_stall();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage directly downstream of the ID/EX pipeline register.
- Resolves operand forwarding, performs the RV32I ALU operation, resolves branches, jal and jalr, and issues the PC redirect and flush.
- Registers the results into the EX/MEM pipeline register that feeds the data-memory AXI master.
- Holds its EX/MEM outputs while the memory stage is stalled.

Parameters:
XLEN, 32, datapath width
RESET_PC, 32'h0, value of o_redirect_pc out of reset

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
i_mnemonic  in  6  decoded op; encodings from the team's shared mnemonic package; 0 = bubble
i_rs1_data, i_rs2_data  in  32  register-file operands
i_rs1_addr, i_rs2_addr  in  5  source register indices
i_rd_addr  in  5  destination index
i_rd_wr  in  1  destination write enable
i_imm  in  32  sign-extended immediate
i_ALUsrc1  in  1  1 = operand A is i_pc
i_ALUsrc2  in  1  1 = operand B is i_imm
i_pc  in  32  PC of the instruction in EX
i_DM_OE  in  1  load
i_store  in  1  store
i_funct3  in  3  branch condition / memory size
i_b_inst, i_jal, i_jalr  in  1  control-flow class
i_mem_rd_wr  in  1  EX/MEM writes rd (fed back from own output)
i_mem_rd_addr  in  5  EX/MEM rd
i_mem_result  in  32  EX/MEM ALU result
i_wb_rd_wr  in  1  MEM/WB writes rd
i_wb_rd_addr  in  5  MEM/WB rd
i_wb_data  in  32  MEM/WB write-back data
i_mem_stall  in  1  memory stage busy; hold EX/MEM
o_flush  out  1  kill IF/ID and ID/EX contents
o_redirect_pc  out  32  fetch target while o_flush is high
o_alu_result  out  32  registered result / memory address
o_store_data  out  32  registered forwarded rs2
o_rd_addr  out  5  registered
o_rd_wr  out  1  registered
o_DM_OE  out  1  registered
o_store  out  1  registered
o_funct3  out  3  registered

Behaviour:
- Reset: all registered outputs are 0, the redirect_done flag is 0, o_flush is 0, and o_redirect_pc equals RESET_PC.
- Forwarding for rs1 and rs2, evaluated independently:
  - First priority: EX/MEM, when i_mem_rd_wr is set, i_mem_rd_addr is nonzero and i_mem_rd_addr equals the source index.
  - Second priority: MEM/WB under the same conditions.
  - Otherwise the register-file value is used.
  - x0 is never forwarded.
- Operand A = i_ALUsrc1 ? i_pc : fwd_rs1.
- Operand B = i_ALUsrc2 ? i_imm : fwd_rs2.
- ALU:
  - ADD covers loads, stores and AUIPC; SUB.
  - SLL, SRL and SRA use B[4:0] as the shift amount.
  - SLT is signed and SLTU is unsigned; each yields 32'd1 or 32'd0.
  - XOR, OR, AND.
  - LUI passes B.
  - Any unlisted or bubble mnemonic yields 0.
  - All arithmetic is modulo 2^32.
- jal and jalr: the result is i_pc+4.
- Branch taken conditions (on fwd_rs1 vs fwd_rs2):
  - funct3 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
  - funct3 010 and 011 are never taken.
- Targets:
  - branch and jal: i_pc+i_imm.
  - jalr: (fwd_rs1+i_imm) & ~32'd1.
- Redirect (combinational):
  - taken = (i_b_inst & cond) | i_jal | i_jalr.
  - o_flush = taken & ~redirect_done.
  - o_redirect_pc = target while o_flush is high; otherwise it holds its last value.
- redirect_done flag:
  - Set on a clock edge where o_flush=1 and i_mem_stall=1.
  - Cleared on any edge where i_mem_stall=0.
  - Each control instruction therefore flushes exactly once, even if it sits in EX for several stalled cycles.
- EX/MEM register:
  - When i_mem_stall=0, loads every output from the current EX values on each edge.
  - When i_mem_stall=1, every output holds.
  - Latency is 1 cycle from EX inputs to outputs.
  - No bubble is inserted here; upstream handles the load-use hazard.
- Simultaneous events:
  - A flush together with a non-stalled edge still registers the control instruction itself, so the jal/jalr link write proceeds.
  - A reset mid-stall clears redirect_done and all outputs immediately.

Test Plan:
- ADD x3 with i_rs1_data=5, i_rs2_data=7, no stall → after 1 edge o_alu_result=12, o_rd_addr=3, o_rd_wr=1.
- Back-to-back forwarding: i_mem_rd_wr=1, i_mem_rd_addr=5, i_mem_result=0x10; i_wb_rd_wr=1, i_wb_rd_addr=5, i_wb_data=0x20; rs1=x5, i_rs1_data=0, ADD with imm=1 → o_alu_result=0x11 (EX/MEM wins); the same case with rd_addr=0 → 1.
- BLT, fwd_rs1=32'hFFFFFFFF, fwd_rs2=1, pc=0x100, imm=-8 → o_flush=1, o_redirect_pc=0xF8; the same with BLTU → o_flush=0.
- JALR, rs1=0x2003, imm=4, pc=0x40 → o_redirect_pc=0x2006, o_alu_result=0x44 registered.
- JAL with i_mem_stall=1 for 3 cycles → o_flush high only in the first cycle; outputs hold their prior values; when the stall drops, o_alu_result=pc+4.
- Assert rst during a stalled jal → all outputs 0, o_flush=0 and redirect_done cleared; after release the same jal flushes once again.
